// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer.
// master: the sequencing logic that loads, starts and pauses the timer.
// slave:  the timer itself, which reports count, busy and done.
interface countdown_timer_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             pause;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output load, load_val, start, pause,
    input  count, busy, done
  );

  modport slave (
    input  load, load_val, start, pause,
    output count, busy, done
  );
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter used as a cycle-delay / timeout
// generator. A loaded value counts down to zero after start. pause freezes
// the count. A one-cycle done pulse is emitted at terminal count.
// Optional feature: define COUNTDOWN_AUTO_RELOAD_EN to make the timer
// periodic. The value captured by load is then reloaded at terminal count.
// Edge priority: reset_n > load > pause > start.
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  countdown_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state, state_next;
  logic [WIDTH-1:0] count_q, count_next;
  logic             done_q, done_next;
  logic             busy_q, busy_next;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q;

  // Capture the period on every load so the terminal edge can restart the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reload_q <= '0;
    end else if (bus.load) begin
      reload_q <= bus.load_val;
    end
  end
`endif

  // Next-state, next-count and output decode. pause outranks start, so a
  // start seen together with pause in IDLE is not taken.
  always_comb begin
    state_next = state;
    count_next = count_q;
    done_next  = 1'b0;
    if (bus.load) begin
      count_next = bus.load_val;
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.pause && bus.start) begin
            if (count_q != '0) begin
              state_next = RUN;
            end else begin
              done_next = 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.pause) begin
            state_next = HOLD;
          end else if (count_q == ONE) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            done_next = 1'b1;
            if (reload_q != '0) begin
              count_next = reload_q;
            end else begin
              count_next = '0;
              state_next = DONE;
            end
`else
            count_next = '0;
            done_next  = 1'b1;
            state_next = DONE;
`endif
          end else if (count_q != '0) begin
            count_next = count_q - ONE;
          end else begin
            state_next = IDLE;
          end
        end
        HOLD: begin
          if (!bus.pause) begin
            state_next = RUN;
          end
        end
        DONE: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
    busy_next = (state_next == RUN) || (state_next == HOLD);
  end

  // State and registered outputs. Reset clears everything immediately with no done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_next;
      count_q <= count_next;
      done_q  <= done_next;
      busy_q  <= busy_next;
    end
  end

  assign bus.count = count_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus a
// randomized run against a behavioural model of the timer rules.
module tb_countdown_timer;
  localparam int WIDTH = 4;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  int   compared   = 0;
  int   mismatched = 0;

  // Behavioural model: counting/paused/cooldown flags plus plain arithmetic.
  int m_count, m_reload;
  bit m_active, m_paused, m_cooldown, m_done;

  countdown_timer_if #(.WIDTH(WIDTH)) bus ();

  countdown_timer #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  task automatic drive(input bit ld, input int lv, input bit st, input bit ps);
    bus.load     = ld;
    bus.load_val = WIDTH'(lv);
    bus.start    = st;
    bus.pause    = ps;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_step(input bit ld, input int lv, input bit st, input bit ps);
    m_done = 1'b0;
    if (ld) begin
      m_count    = lv;
      m_reload   = lv;
      m_active   = 1'b0;
      m_paused   = 1'b0;
      m_cooldown = 1'b0;
    end else if (m_cooldown) begin
      m_cooldown = 1'b0;
    end else if (m_active) begin
      if (m_paused) begin
        if (!ps) m_paused = 1'b0;
      end else if (ps) begin
        m_paused = 1'b1;
      end else if (AUTO && m_count == 1 && m_reload != 0) begin
        m_count = m_reload;
        m_done  = 1'b1;
      end else begin
        m_count = m_count - 1;
        if (m_count == 0) begin
          m_done     = 1'b1;
          m_active   = 1'b0;
          m_cooldown = 1'b1;
        end
      end
    end else if (st && !ps) begin
      if (m_count == 0) m_done = 1'b1;
      else              m_active = 1'b1;
    end
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0);
    reset_n = 1'b0;
    #12;
    compared++;
    if (bus.count !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_state: count=%0d busy=%b done=%b, need 0/0/0", bus.count, bus.busy, bus.done);
    end
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      compared++;
      if (bus.count !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL reset_idle[%0d]: count=%0d busy=%b done=%b, need 0/0/0", i, bus.count, bus.busy, bus.done);
      end
    end
  endtask

  task automatic test_countdown();
    int exp_seq[3] = '{2, 1, 0};
    drive(1, 3, 0, 0); tick();
    compared++;
    if (bus.count !== 4'd3 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL countdown_load: count=%0d busy=%b done=%b, need 3/0/0", bus.count, bus.busy, bus.done);
    end
    drive(0, 0, 1, 0); tick();
    drive(0, 0, 0, 0);
    compared++;
    if (bus.count !== 4'd3 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL countdown_start: count=%0d busy=%b done=%b, need 3/1/0", bus.count, bus.busy, bus.done);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++;
      if (bus.count !== WIDTH'(exp_seq[i]) || bus.done !== (exp_seq[i] == 0) || bus.busy !== (exp_seq[i] != 0)) begin
        mismatched++;
        $display("[TB] FAIL countdown_step[%0d]: count=%0d busy=%b done=%b, need count=%0d", i, bus.count, bus.busy, bus.done, exp_seq[i]);
      end
    end
    tick();
    compared++;
    if (bus.count !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL countdown_after_done: count=%0d busy=%b done=%b, need 0/0/0", bus.count, bus.busy, bus.done);
    end
  endtask

  task automatic test_pause();
    int exp_seq[9] = '{4, 3, 3, 3, 3, 3, 2, 1, 0};
    int pause_at[9] = '{0, 0, 1, 1, 1, 0, 0, 0, 0};
    int pulses = 0;
    drive(1, 5, 0, 0); tick();
    drive(0, 0, 1, 0); tick();
    // Step i drives pause for the edge that produces exp_seq[i].
    for (int i = 0; i < 9; i++) begin
      drive(0, 0, 0, pause_at[i] != 0);
      tick();
      if (bus.done === 1'b1) pulses++;
      compared++;
      if (bus.count !== WIDTH'(exp_seq[i])) begin
        mismatched++;
        $display("[TB] FAIL pause_step[%0d]: count=%0d, need %0d", i, bus.count, exp_seq[i]);
      end
    end
    drive(0, 0, 0, 0);
    tick();
    if (bus.done === 1'b1) pulses++;
    compared++;
    if (pulses != 1) begin
      mismatched++;
      $display("[TB] FAIL pause_done_pulses: got %0d, need 1", pulses);
    end
  endtask

  task automatic test_load_start();
    int term_count = AUTO ? 4 : 0;
    drive(1, 4, 1, 0); tick();
    drive(0, 0, 0, 0);
    compared++;
    if (bus.count !== 4'd4 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL load_start_same_edge: count=%0d busy=%b done=%b, need 4/0/0", bus.count, bus.busy, bus.done);
    end
    tick();
    compared++;
    if (bus.count !== 4'd4 || bus.busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL load_start_no_decrement: count=%0d busy=%b, need 4/0", bus.count, bus.busy);
    end
    drive(0, 0, 1, 0); tick();
    drive(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick();
    compared++;
    if (bus.count !== WIDTH'(term_count) || bus.done !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL load_start_later_run: count=%0d done=%b, need %0d/1", bus.count, bus.done, term_count);
    end
    drive(1, 0, 0, 0); tick();
    drive(0, 0, 0, 0); tick();
  endtask

  task automatic test_reset_midcount();
    drive(1, 6, 0, 0); tick();
    drive(0, 0, 1, 0); tick();
    drive(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick();
    compared++;
    if (bus.count !== 4'd2 || bus.busy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL midcount_setup: count=%0d busy=%b, need 2/1", bus.count, bus.busy);
    end
    #2 reset_n = 1'b0;
    #1;
    compared++;
    if (bus.count !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL midcount_async_reset: count=%0d busy=%b done=%b, need 0/0/0", bus.count, bus.busy, bus.done);
    end
    tick();
    reset_n = 1'b1;
    tick();
    compared++;
    if (bus.count !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL midcount_after_reset: count=%0d busy=%b done=%b, need 0/0/0", bus.count, bus.busy, bus.done);
    end
  endtask

  task automatic test_auto_reload();
    drive(1, 2, 0, 0); tick();
    drive(0, 0, 1, 0); tick();
    drive(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      compared++;
      if (bus.count !== ((i % 2 == 0) ? 4'd1 : 4'd2) || bus.done !== (i % 2 == 1) || bus.busy !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL reload_step[%0d]: count=%0d busy=%b done=%b", i, bus.count, bus.busy, bus.done);
      end
    end
    drive(1, 7, 0, 0); tick();
    drive(0, 0, 0, 0); tick();
    compared++;
    if (bus.count !== 4'd7 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reload_stopped_by_load: count=%0d busy=%b done=%b, need 7/0/0", bus.count, bus.busy, bus.done);
    end
  endtask

  task automatic test_random();
    bit ld, st, ps;
    int lv;
    m_count = 0; m_reload = 0;
    m_active = 0; m_paused = 0; m_cooldown = 0; m_done = 0;
    for (int i = 0; i < 400; i++) begin
      ld = (i == 0) || ($urandom_range(0, 9) == 0);
      lv = int'($urandom_range(0, 6));
      ps = ($urandom_range(0, 4) == 0);
      st = !ps && ($urandom_range(0, 2) == 0);
      drive(ld, lv, st, ps);
      model_step(ld, lv, st, ps);
      tick();
      compared++;
      if (bus.count !== WIDTH'(m_count) || bus.busy !== m_active || bus.done !== m_done) begin
        mismatched++;
        $display("[TB] FAIL random[%0d]: count=%0d busy=%b done=%b, need count=%0d busy=%b done=%b",
                 i, bus.count, bus.busy, bus.done, m_count, m_active, m_done);
      end
    end
    drive(0, 0, 0, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    drive(0, 0, 0, 0);
    test_reset();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    test_auto_reload();
`else
    test_countdown();
    test_pause();
`endif
    test_load_start();
    test_reset_midcount();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
